// File: rtl/rx_serial_8e1_if.sv
// Serial receiver bus: line and clear toward the receiver, received byte,
// status flags and debug state back to the consumer.
interface rx_serial_8e1_if;
  logic       dado_serial;
  logic       limpa;
  logic [7:0] dados_ascii;
  logic       tem_dado;
  logic       pronto;
  logic       erro_paridade;
  logic       erro_stop;
  logic [3:0] db_estado;

  modport master (
    output dado_serial, limpa,
    input  dados_ascii, tem_dado, pronto, erro_paridade, erro_stop, db_estado
  );

  modport slave (
    input  dado_serial, limpa,
    output dados_ascii, tem_dado, pronto, erro_paridade, erro_stop, db_estado
  );
endinterface

// File: rtl/rx_serial_8e1.sv
// 8E1 asynchronous serial receiver: synchronizes the line, samples each bit at
// mid-period, checks even parity and stop bit, and holds the byte until cleared.
module rx_serial_8e1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N            = 13
) (
  input logic            clock,
  input logic            reset,
  rx_serial_8e1_if.slave bus
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    MEIO_START = 4'd1,
    RECEBE     = 4'd2,
    PARIDADE   = 4'd3,
    STOP       = 4'd4,
    ARMAZENA   = 4'd5
  } state_t;

  state_t       state_q;
  logic         sync1_q, sync2_q;
  logic [N-1:0] cnt_q, cnt_d;
  logic [2:0]   bitIdx_q;
  logic [7:0]   shift_q;
  logic         parity_q, stop_q;
  logic [7:0]   dados_q;
  logic         temDado_q, pronto_q, erroPar_q, erroStop_q;
  logic         atWrap, atHalf;

  // Both flops preset high so reset looks like an idle line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.dado_serial;
      sync2_q <= sync1_q;
    end
  end

  assign atWrap = (cnt_q == N'(CLKS_PER_BIT - 1));
  assign atHalf = (cnt_q == N'(CLKS_PER_BIT / 2 - 1));

  always_comb begin
    cnt_d = atWrap ? '0 : cnt_q + N'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= INICIAL;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      stop_q     <= 1'b0;
      dados_q    <= '0;
      temDado_q  <= 1'b0;
      pronto_q   <= 1'b0;
      erroPar_q  <= 1'b0;
      erroStop_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      cnt_q    <= cnt_d;
      // A clear in the same cycle as a store is overridden by the store below.
      if (bus.limpa) begin
        temDado_q  <= 1'b0;
        erroPar_q  <= 1'b0;
        erroStop_q <= 1'b0;
      end
      case (state_q)
        INICIAL: begin
          if (!sync2_q) begin
            state_q <= MEIO_START;
            cnt_q   <= '0;
          end
        end
        MEIO_START: begin
          if (atHalf) begin
            cnt_q    <= '0;
            bitIdx_q <= '0;
            state_q  <= sync2_q ? INICIAL : RECEBE;
          end
        end
        RECEBE: begin
          if (atWrap) begin
            shift_q  <= {sync2_q, shift_q[7:1]};
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) state_q <= PARIDADE;
          end
        end
        PARIDADE: begin
          if (atWrap) begin
            parity_q <= sync2_q;
            state_q  <= STOP;
          end
        end
        STOP: begin
          if (atWrap) begin
            stop_q  <= sync2_q;
            state_q <= ARMAZENA;
          end
        end
        ARMAZENA: begin
          dados_q    <= shift_q;
          erroPar_q  <= ^{shift_q, parity_q};
          erroStop_q <= ~stop_q;
          temDado_q  <= 1'b1;
          pronto_q   <= 1'b1;
          state_q    <= INICIAL;
        end
        default: state_q <= INICIAL;
      endcase
    end
  end

  assign bus.dados_ascii   = dados_q;
  assign bus.tem_dado      = temDado_q;
  assign bus.pronto        = pronto_q;
  assign bus.erro_paridade = erroPar_q;
  assign bus.erro_stop     = erroStop_q;
  assign bus.db_estado     = state_q;

endmodule

// File: tb/tb_rx_serial_8e1.sv
// Directed bench for rx_serial_8e1: drives 8E1 frames bit by bit and checks
// the received byte, flags, pronto timing and debug state.
module tb_rx_serial_8e1;
  localparam int CLKS = 434;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycleCount = 0;
  int   prontoCount = 0;
  int   lastProntoCycle = 0;
  int   prevProntoCycle = 0;
  int   frameStart = 0;
  int   base;

  rx_serial_8e1_if bus();

  rx_serial_8e1 dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Pronto is logged on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (bus.pronto === 1'b1) begin
      prontoCount     = prontoCount + 1;
      prevProntoCycle = lastProntoCycle;
      lastProntoCycle = cycleCount;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Call aligned just after a clock edge; leaves the line at the stop value.
  task automatic applyStimulus(input logic [7:0] data, input logic par,
                               input logic stopBit, input bit holdStop);
    logic [10:0] bits;
    bits = {stopBit, par, data, 1'b0};
    frameStart = cycleCount + 1;
    for (int i = 0; i < 11; i++) begin
      bus.dado_serial = bits[i];
      if (i < 10 || holdStop) begin
        repeat (CLKS) @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic waitPronto(input int target, input int budget);
    for (int i = 0; i < budget && prontoCount < target; i++) @(negedge clock);
  endtask

  initial begin
    logic [10:0] partial;
    bus.dado_serial = 1'b1;
    bus.limpa       = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    checkOutput("rst_dados", bus.dados_ascii, 8'h00);
    checkOutput("rst_tem_dado", bus.tem_dado, 1'b0);
    checkOutput("rst_pronto", bus.pronto, 1'b0);
    checkOutput("rst_erro_par", bus.erro_paridade, 1'b0);
    checkOutput("rst_erro_stop", bus.erro_stop, 1'b0);
    checkOutput("rst_db_estado", bus.db_estado, 4'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (5) @(posedge clock); #1;

    // 1: 0x55, parity 0, stop 1
    base = prontoCount;
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b1);
    waitPronto(base + 1, 200);
    @(negedge clock);
    checkOutput("t1_pronto_count", prontoCount, base + 1);
    checkOutput("t1_latency_4560pm1",
                ((lastProntoCycle - frameStart) >= 4559) &&
                ((lastProntoCycle - frameStart) <= 4561), 1'b1);
    checkOutput("t1_dados", bus.dados_ascii, 8'h55);
    checkOutput("t1_tem_dado", bus.tem_dado, 1'b1);
    checkOutput("t1_erro_par", bus.erro_paridade, 1'b0);
    checkOutput("t1_erro_stop", bus.erro_stop, 1'b0);
    checkOutput("t1_pronto_low", bus.pronto, 1'b0);

    // 2: 0x07 with wrong parity, then limpa
    @(posedge clock); #1;
    applyStimulus(8'h07, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    checkOutput("t2_dados", bus.dados_ascii, 8'h07);
    checkOutput("t2_erro_par", bus.erro_paridade, 1'b1);
    @(posedge clock); #1;
    bus.limpa = 1'b1;
    @(posedge clock); #1;
    bus.limpa = 1'b0;
    @(negedge clock);
    checkOutput("t2_limpa_tem_dado", bus.tem_dado, 1'b0);
    checkOutput("t2_limpa_erro_par", bus.erro_paridade, 1'b0);
    checkOutput("t2_limpa_dados", bus.dados_ascii, 8'h07);

    // 3: 0xA3 with stop bit 0, line held low afterwards
    @(posedge clock); #1;
    base = prontoCount;
    applyStimulus(8'hA3, 1'b0, 1'b0, 1'b0);
    waitPronto(base + 1, 1000);
    checkOutput("t3_pronto_count", prontoCount, base + 1);
    checkOutput("t3_erro_stop", bus.erro_stop, 1'b1);
    checkOutput("t3_erro_par", bus.erro_paridade, 1'b0);
    checkOutput("t3_dados", bus.dados_ascii, 8'hA3);
    for (int i = 0; i < 3 && bus.db_estado == 4'd0; i++) begin
      @(posedge clock); #1;
    end
    checkOutput("t3_leaves_inicial", bus.db_estado, 4'd1);
    repeat (20) @(posedge clock); #1;
    bus.dado_serial = 1'b1;
    repeat (400) @(posedge clock); #1;
    checkOutput("t3_back_inicial", bus.db_estado, 4'd0);
    checkOutput("t3_no_extra_pronto", prontoCount, base + 1);

    // 4: 100-cycle glitch on an idle line
    base = prontoCount;
    repeat (10) @(posedge clock); #1;
    bus.dado_serial = 1'b0;
    repeat (50) @(posedge clock); #1;
    checkOutput("t4_in_meio_start", bus.db_estado, 4'd1);
    repeat (50) @(posedge clock); #1;
    bus.dado_serial = 1'b1;
    repeat (300) @(posedge clock); #1;
    checkOutput("t4_back_inicial", bus.db_estado, 4'd0);
    checkOutput("t4_no_pronto", prontoCount, base);
    checkOutput("t4_dados_kept", bus.dados_ascii, 8'hA3);
    checkOutput("t4_tem_dado_kept", bus.tem_dado, 1'b1);
    checkOutput("t4_erro_stop_kept", bus.erro_stop, 1'b1);

    // 5: 0x41 and 0x42 back to back
    repeat (10) @(posedge clock); #1;
    base = prontoCount;
    applyStimulus(8'h41, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h42, 1'b0, 1'b1, 1'b1);
    waitPronto(base + 2, 200);
    @(negedge clock);
    checkOutput("t5_pronto_count", prontoCount, base + 2);
    checkOutput("t5_pronto_gap", lastProntoCycle - prevProntoCycle, 4774);
    checkOutput("t5_dados", bus.dados_ascii, 8'h42);
    checkOutput("t5_tem_dado", bus.tem_dado, 1'b1);
    checkOutput("t5_erro_stop", bus.erro_stop, 1'b0);

    // 6: reset during the 5th data bit, then 0xFF
    @(posedge clock); #1;
    partial = {1'b1, 1'b0, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.dado_serial = partial[i];
      repeat (CLKS) @(posedge clock); #1;
    end
    bus.dado_serial = partial[5];
    repeat (200) @(posedge clock);
    #3;
    checkOutput("t6_pre_reset_state", bus.db_estado, 4'd2);
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_dados", bus.dados_ascii, 8'h00);
    checkOutput("t6_rst_tem_dado", bus.tem_dado, 1'b0);
    checkOutput("t6_rst_db_estado", bus.db_estado, 4'd0);
    checkOutput("t6_rst_erro_stop", bus.erro_stop, 1'b0);
    bus.dado_serial = 1'b1;
    repeat (3) @(posedge clock); #1;
    reset = 1'b1;
    repeat (10) @(posedge clock); #1;
    base = prontoCount;
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1);
    waitPronto(base + 1, 200);
    @(negedge clock);
    checkOutput("t6_pronto_count", prontoCount, base + 1);
    checkOutput("t6_dados", bus.dados_ascii, 8'hFF);
    checkOutput("t6_tem_dado", bus.tem_dado, 1'b1);
    checkOutput("t6_erro_par", bus.erro_paridade, 1'b0);
    checkOutput("t6_erro_stop", bus.erro_stop, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
